// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register and instruction-memory request driver.
// Takes the EX-stage branch decision, redirects fetch to the branch target,
// holds a multi-cycle flush after each redirect, traps misaligned targets
// and keeps a saturating count of accepted redirects.
module pc_redirect_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic            flush,
  output logic            misalign_err,
  output logic [15:0]     redirect_cnt
);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH, ERR} state_t;

  // Counter is loaded with the number of extra flush cycles after the first.
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [2:0]      flush_cnt;

  assign imem_addr = pc;

  // Single FSM: state, PC, flush counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      flush_cnt    <= '0;
      imem_req     <= 1'b0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      // misalign_err is a pulse; only the FETCH trap branch raises it.
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          flush    <= 1'b0;
        end
        FETCH: begin
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            // Misaligned target: stop fetching for good, keep pipe killed.
            state        <= ERR;
            misalign_err <= 1'b1;
            imem_req     <= 1'b0;
            flush        <= 1'b1;
          end else if (branch_taken) begin
            // Redirect beats stall and a pending unaccepted request.
            state     <= FLUSH;
            pc        <= branch_target;
            flush_cnt <= FLUSH_LAST;
            imem_req  <= 1'b1;
            flush     <= 1'b1;
            if (redirect_cnt != 16'hFFFF)
              redirect_cnt <= redirect_cnt + 16'd1;
          end else if (!stall && imem_ready) begin
            pc <= pc + PC_STEP;
          end
        end
        FLUSH: begin
          // Branch/stall here come from killed instructions; ignore them.
          if (imem_ready)
            pc <= pc + PC_STEP;
          if (flush_cnt == 3'd0) begin
            state <= FETCH;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        ERR: begin
          state    <= ERR;
          imem_req <= 1'b0;
          flush    <= 1'b1;
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
          flush    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Program-counter and fetch-redirect stage that directly consumes the `branch` decision produced by the branch control unit. It holds the architectural fetch PC and issues instruction-memory requests with a valid/ready handshake. On a taken branch it redirects fetch to the branch target and asserts a multi-cycle pipeline flush. It also traps misaligned targets and keeps a saturating count of taken redirects. It sits between the EX-stage branch logic and the instruction-memory port, feeding the IF/ID register.

## Interface
Parameters:
- XLEN, 32, PC / address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FLUSH_CYCLES, 2, cycles `flush` stays high per redirect (legal range 1..7)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- branch_taken  in  1  taken decision from branch control (EX stage)
- branch_target  in  XLEN  redirect address, valid when branch_taken=1
- stall  in  1  hazard stall from decode; holds the PC
- imem_ready  in  1  instruction memory accepts the current request
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (equals current PC)
- flush  out  1  kill IF/ID and ID/EX contents
- misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned
- redirect_cnt  out  16  saturating count of accepted redirects

## Operation
- States: BOOT, FETCH, FLUSH, ERR.
- All outputs are driven from registers or state. `imem_addr` is always equal to `pc`.
- Reset (async, any time, including mid-flush) forces:
  - state=BOOT, pc=RESET_PC
  - imem_req=0, flush=0, misalign_err=0, redirect_cnt=0
  - internal flush counter=0
- BOOT: lasts one cycle after reset deasserts, then goes to FETCH. `imem_req` stays 0 in BOOT.
- FETCH: imem_req=1. Priority order:
  - branch_taken=1 and branch_target[1:0]!=0: set misalign_err=1 for the next cycle; go to ERR. pc is unchanged.
  - branch_taken=1 and target aligned: pc<=branch_target; go to FLUSH; flush counter<=FLUSH_CYCLES-1; redirect_cnt increments, saturating at 16'hFFFF. The redirect wins over stall and over imem_ready=0; the outstanding request is abandoned.
  - stall=1 or imem_ready=0: pc holds.
  - Otherwise: pc<=pc+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC goes to 0).
- FLUSH: flush=1 and imem_req=1 at the new pc.
  - branch_taken and stall are ignored, because they come from killed instructions.
  - pc<=pc+4 whenever imem_ready=1.
  - The counter decrements each cycle. When the counter is 0, the next state is FETCH.
- ERR: imem_req=0 and flush=1. The state is held until reset. misalign_err is high only for the first ERR cycle.
- redirect_cnt never wraps.

## Timing
- A redirect sampled at edge N is visible after edge N:
  - imem_addr=target
  - flush=1 for exactly FLUSH_CYCLES cycles (edges N..N+FLUSH_CYCLES-1 → high)
  - redirect_cnt updated
- Fetch latency: a request is accepted on any edge where imem_req=1 and imem_ready=1. The pc advances on that same edge.
- First request after reset release: imem_req rises one cycle after the first clk edge with rst=0 (the BOOT cycle). The request address is RESET_PC.
- Back-to-back redirects are impossible: a branch in the cycle FLUSH exits is treated as a new FETCH-state event only from the FETCH cycle onward.
- Simultaneous stall=1 and branch_taken=1 in FETCH: the redirect is taken.
- Reset asserted during FLUSH: flush drops to 0 asynchronously, without waiting for a clock edge.

## Test plan
- Reset release with RESET_PC=0, imem_ready=1 constantly → imem_addr sequence 0 (BOOT, req=0), 0, 4, 8, 12. imem_req goes high on the 2nd cycle.
- Taken branch in FETCH at pc=0x10 with target 0x200 → next cycle imem_addr=0x200, flush high for 2 cycles, then 0x204, 0x208. redirect_cnt=1.
- imem_ready=0 for 3 cycles at pc=0x40, with branch_taken raised in the 2nd of those cycles to target 0x80 → pc=0x80, flush asserted, and no advance to 0x44.
- stall=1 and branch_taken=1 in the same cycle, target 0x100 → redirect occurs. Then stall=1 during FLUSH → pc still advances 0x100 → 0x104.
- Misaligned target 0x202 → misalign_err is a single-cycle pulse, imem_req=0, flush=1. Further branches are ignored until rst, after which pc=RESET_PC.
- pc=32'hFFFF_FFFC with imem_ready=1 → wraps to 0. Preload the counter with 65535 redirects, then one more redirect → redirect_cnt stays 16'hFFFF. Assert rst mid-FLUSH → all outputs reach their reset values immediately.
